intra_edge_filter_stream: RTL



---
 rtl/intra_edge_filter_stream.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/intra_edge_filter_stream.sv
// Streaming AV1 intra edge filter: loads one edge, applies the strength-selected 5-tap kernel,
// streams the result out. Define INTRA_EDGE_STRENGTH3_EN to build the full 5-tap datapath.
module intra_edge_filter_stream #(
   parameter int unsigned BIT_DEPTH = 10,
   parameter int unsigned CHANNELS  = 3,
   parameter int unsigned MAX_LEN   = 64
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [1:0]                          strength,
   input  logic [$clog2(MAX_LEN+2)-1:0]        len,
   input  logic                                in_valid,
   input  logic [CHANNELS*BIT_DEPTH-1:0]       in_data,
   output logic                                in_ready,
   output logic                                out_valid,
   output logic [CHANNELS*BIT_DEPTH-1:0]       out_data,
   input  logic                                out_ready,
   output logic                                out_last,
   output logic                                busy
);

   localparam int unsigned LW    = $clog2(MAX_LEN+2);
   localparam int unsigned DW    = CHANNELS*BIT_DEPTH;
   localparam int unsigned AccW  = BIT_DEPTH+5;
   localparam int unsigned Depth = MAX_LEN+1;
   localparam logic [LW-1:0] SzMax = LW'(Depth);

`ifdef INTRA_EDGE_STRENGTH3_EN
   localparam int TapLo = 0;
   localparam int TapHi = 4;
`else
   // Outer taps are zero for strengths 1 and 2, so they are not built.
   localparam int TapLo = 1;
   localparam int TapHi = 3;
`endif

   typedef enum logic [1:0] {StIdle, StLoad, StFilter} state_e;

   state_e            state_q;
   logic [1:0]        str_q;
   logic [LW-1:0]     sz_q;
   logic [LW-1:0]     wr_q;
   logic [LW-1:0]     rd_q;
   logic              out_valid_q;
   logic              out_last_q;
   logic [DW-1:0]     out_data_q;
   logic [DW-1:0]     smp_q [Depth];

   logic [LW-1:0]     len_clamped;
   logic [3:0]        k [TapLo:TapHi];
   logic [LW-1:0]     tap_idx [TapLo:TapHi];
   logic [AccW-1:0]   acc;
   logic [DW-1:0]     filt_word;
   logic [DW-1:0]     next_data;
   int                t;

   assign in_ready  = (state_q == StLoad);
   assign busy      = (state_q != StIdle);
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;

   always_comb begin
      len_clamped = len;
      if (len == '0) begin
         len_clamped = LW'(1);
      end else if (len > SzMax) begin
         len_clamped = SzMax;
      end
   end

   always_comb begin
      for (int j = TapLo; j <= TapHi; j++) begin
         k[j] = 4'd0;
      end
      case (str_q)
         2'd1: begin
            k[1] = 4'd4;
            k[2] = 4'd8;
            k[3] = 4'd4;
         end
         2'd2: begin
            k[1] = 4'd5;
            k[2] = 4'd6;
            k[3] = 4'd5;
         end
`ifdef INTRA_EDGE_STRENGTH3_EN
         2'd3: begin
            k[0] = 4'd2;
            k[1] = 4'd4;
            k[2] = 4'd4;
            k[3] = 4'd4;
            k[4] = 4'd2;
         end
`else
         2'd3: begin
            k[1] = 4'd5;
            k[2] = 4'd6;
            k[3] = 4'd5;
         end
`endif
         default: ;
      endcase
   end

   // Tap positions replicate the edge end samples outside 0..sz-1.
   always_comb begin
      t = 0;
      for (int j = TapLo; j <= TapHi; j++) begin
         t = int'(rd_q) + j - 2;
         if (t < 0) begin
            t = 0;
         end
         if (t > int'(sz_q) - 1) begin
            t = int'(sz_q) - 1;
         end
         tap_idx[j] = LW'(t);
      end
   end

   always_comb begin
      filt_word = '0;
      acc       = '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
         acc = '0;
         for (int j = TapLo; j <= TapHi; j++) begin
            acc = acc + AccW'(k[j]) * AccW'(smp_q[tap_idx[j]][c*BIT_DEPTH +: BIT_DEPTH]);
         end
         filt_word[c*BIT_DEPTH +: BIT_DEPTH] = BIT_DEPTH'((acc + AccW'(8)) >> 4);
      end
   end

   always_comb begin
      next_data = filt_word;
      if (str_q == 2'd0 || rd_q == '0) begin
         next_data = smp_q[rd_q];
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == StLoad && in_valid) begin
         smp_q[wr_q] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         str_q       <= '0;
         sz_q        <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  str_q   <= strength;
                  sz_q    <= len_clamped;
                  wr_q    <= '0;
                  state_q <= StLoad;
               end
            end
            StLoad: begin
               if (in_valid) begin
                  wr_q <= wr_q + LW'(1);
                  if (wr_q == sz_q - LW'(1)) begin
                     rd_q    <= '0;
                     state_q <= StFilter;
                  end
               end
            end
            StFilter: begin
               if (out_valid_q && out_ready && out_last_q) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  state_q     <= StIdle;
               end else if (!out_valid_q || out_ready) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= next_data;
                  out_last_q  <= (rd_q == sz_q - LW'(1));
                  rd_q        <= rd_q + LW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
